// File: rtl/picorv32_mem_responder.sv
// Target-side responder for the picorv32 native memory bus: word RAM with byte strobes,
// configurable wait states, out-of-range flag and transaction counters. Option: RESP_LFSR_WAIT_EN.
module picorv32_mem_responder #(
    parameter int MEM_WORDS   = 1024,
    parameter int WAIT_CYCLES = 0,
    parameter int INIT_ZERO   = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        err_oor,
    output logic [31:0] xfer_count,
    output logic [31:0] fetch_count
);
    localparam int AW = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t       state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [31:2]  addr_q, addr_d;
    logic [31:0]  wdata_q, wdata_d;
    logic [3:0]   wstrb_q, wstrb_d;
    logic         instr_q, instr_d;
    logic [31:0]  rdata_q, rdata_d;
    logic         err_q, err_d;
    logic [31:0]  xfer_q, xfer_d;
    logic [31:0]  fetch_q, fetch_d;

    logic [4:0]   wait_load;
    logic [31:2]  req_addr;
    logic [31:0]  req_wdata;
    logic [3:0]   req_wstrb;
    logic         req_instr;
    logic         enter_resp;
    logic         in_range;
    logic         wr_en;
    logic [AW-1:0] idx;
    logic [31:0]  rd_word;
    logic         unused_addr_bits;

    assign unused_addr_bits = ^mem_addr[1:0];

`ifdef RESP_LFSR_WAIT_EN
    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr_q <= 16'hACE1;
        else         lfsr_q <= lfsr_d;
    end

    assign wait_load = 5'(WAIT_CYCLES) + {3'b000, lfsr_q[1:0]};
`else
    assign wait_load = 5'(WAIT_CYCLES);
`endif

    // With zero wait states the RAM is accessed on the acceptance edge, so use live inputs in IDLE.
    always_comb begin
        if (state_q == ST_IDLE) begin
            req_addr  = mem_addr[31:2];
            req_wdata = mem_wdata;
            req_wstrb = mem_wstrb;
            req_instr = mem_instr;
        end else begin
            req_addr  = addr_q;
            req_wdata = wdata_q;
            req_wstrb = wstrb_q;
            req_instr = instr_q;
        end
    end

    assign idx      = req_addr[AW+1:2];
    assign in_range = (req_addr[31:AW+2] == '0);
    assign wr_en    = enter_resp && in_range && (req_wstrb != 4'b0000) && resetn;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        instr_d    = instr_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    addr_d  = mem_addr[31:2];
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    instr_d = mem_instr;
                    cnt_d   = wait_load;
                    if (wait_load == 5'd0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q <= 5'd1) begin
                    cnt_d      = 5'd0;
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        xfer_d  = xfer_q;
        fetch_d = fetch_q;
        if (enter_resp) begin
            rdata_d = (in_range && req_wstrb == 4'b0000) ? rd_word : 32'h0;
            err_d   = err_q | ~in_range;
            xfer_d  = xfer_q + 32'd1;
            fetch_d = fetch_q + {31'b0, req_instr};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            instr_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            xfer_q  <= '0;
            fetch_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            instr_q <= instr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            xfer_q  <= xfer_d;
            fetch_q <= fetch_d;
        end
    end

    // RAM is deliberately outside the reset domain so contents survive a reset.
    generate
        if (INIT_ZERO != 0) begin : g_ram_zero
            logic [31:0] ram [MEM_WORDS] = '{default: 32'h0};
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    for (int b = 0; b < 4; b++) begin
                        if (req_wstrb[b]) ram[idx][8*b +: 8] <= req_wdata[8*b +: 8];
                    end
                end
            end
            assign rd_word = ram[idx];
        end else begin : g_ram
            logic [31:0] ram [MEM_WORDS];
            always_ff @(posedge clk) begin
                if (wr_en) begin
                    for (int b = 0; b < 4; b++) begin
                        if (req_wstrb[b]) ram[idx][8*b +: 8] <= req_wdata[8*b +: 8];
                    end
                end
            end
            assign rd_word = ram[idx];
        end
    endgenerate

    assign mem_ready   = (state_q == ST_RESP);
    assign mem_rdata   = rdata_q;
    assign err_oor     = err_q;
    assign xfer_count  = xfer_q;
    assign fetch_count = fetch_q;
endmodule

// File: doc/picorv32_mem_responder.md
Name: picorv32_mem_responder

Overview:
- Target-side model of the picorv32 native memory interface: answers mem_valid requests from the core with a single-cycle mem_ready pulse after a configurable wait-state count.
- Backed by an on-chip word RAM with byte-strobe writes.
- Flags out-of-range accesses and counts completed transactions.
- Sits beside the core in formal and simulation harnesses, replacing free mem_ready/mem_rdata inputs with a consistent memory.

Parameters:
- MEM_WORDS, 1024, RAM depth in 32-bit words; power of two, 16..65536.
- WAIT_CYCLES, 0, wait states per transaction, 0..15.
- INIT_ZERO, 1, when 1 all RAM words are 0 at time zero; when 0 contents are undefined.

Ports:
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- mem_valid  in  1  core request valid
- mem_instr  in  1  request is an instruction fetch
- mem_addr  in  32  byte address; bits [1:0] ignored
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte write enables; 0 = read
- mem_ready  out  1  one-cycle response pulse
- mem_rdata  out  32  read data, valid while mem_ready=1
- err_oor  out  1  sticky out-of-range access flag
- xfer_count  out  32  completed transactions
- fetch_count  out  32  completed transactions with mem_instr=1

Behaviour:
- Clock and reset:
  - Single clock clk; reset is asynchronous, active-low, on resetn.
  - While resetn=0: mem_ready=0, mem_rdata=0, err_oor=0, xfer_count=0, fetch_count=0, FSM=IDLE, wait counter=0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: at an edge with mem_valid=1, latch mem_addr, mem_wdata, mem_wstrb and mem_instr; load wait counter with WAIT_CYCLES.
    - Counter 0 -> go directly to RESP.
    - Otherwise -> go to WAIT.
  - WAIT: decrement the counter each edge. The edge at which the counter reaches 0 -> RESP.
  - RESP: mem_ready=1 for exactly this one cycle; next edge -> IDLE.
  - A new request is sampled in IDLE no earlier than the cycle after RESP. The core's mem_valid in the RESP cycle is ignored.
- Latency: request accepted at edge E0; mem_ready is high in the cycle following edge E0+WAIT_CYCLES. With WAIT_CYCLES=0, mem_ready rises one cycle after acceptance.
- Memory access on the edge entering RESP, using latched values:
  - Word index = addr[log2(MEM_WORDS)+1:2].
  - In range means addr < MEM_WORDS*4.
  - Write (wstrb != 0): byte lane i is updated iff wstrb[i]=1. mem_rdata is set to 0.
  - Read (wstrb = 0): mem_rdata is set to RAM[index], which reflects all prior completed writes.
  - mem_rdata holds its value outside RESP until the next response.
- Out of range:
  - Writes are discarded and reads return 32'h0.
  - err_oor is set at the RESP-entry edge and stays set until reset.
  - The transaction still completes normally with mem_ready.
- Counters:
  - xfer_count increments on the RESP-entry edge; fetch_count also increments if the latched instr=1.
  - Both wrap modulo 2^32.
- Request inputs are sampled only at acceptance. Changes to mem_addr, mem_wdata, mem_wstrb or mem_valid during WAIT or RESP have no effect.
- Reset mid-transaction: mem_ready drops immediately, any pending write is discarded, RAM keeps its prior contents, and the FSM restarts in IDLE.

Optional Feature:
- Macro: RESP_LFSR_WAIT_EN
- Defined:
  - A 16-bit Fibonacci LFSR with taps 16,14,13,11 and seed 16'hACE1 at reset advances every clock while resetn=1.
  - Wait count loaded at acceptance = WAIT_CYCLES + lfsr[1:0], range WAIT_CYCLES..WAIT_CYCLES+3.
  - The sequence is deterministic after reset.
- Undefined: no LFSR logic; wait count is exactly WAIT_CYCLES for every transaction.

Test Plan:
1. WAIT_CYCLES=0: write 32'hDEADBEEF to 0x10 with wstrb=4'hF, then read 0x10 -> each mem_ready pulse lasts 1 cycle, one cycle after acceptance; read returns 32'hDEADBEEF; xfer_count=2.
2. Byte strobes: write 32'h11223344 to 0x20 (wstrb=4'hF), then 32'hAABBCCDD with wstrb=4'b0101, then read -> 32'h11BB33DD.
3. WAIT_CYCLES=3: single read -> mem_ready high exactly 4 cycles after the acceptance edge. Changing mem_addr during WAIT does not change the returned data.
4. Out of range: MEM_WORDS=1024, read 0x1000 -> mem_rdata=0, err_oor=1 and stays 1. A subsequent write to 0x1000 changes no RAM word.
5. Fetch counting: 3 reads with mem_instr=1 and 2 with mem_instr=0 -> fetch_count=3, xfer_count=5.
6. Reset during WAIT of a write to 0x30 (WAIT_CYCLES=5, prior value 32'h0) -> mem_ready=0 immediately, counters=0; after release, read 0x30 returns 32'h0.
